// File: rtl/axi_modport_slice_if.sv
// AXI4 channel bundle used by the register slice and its neighbours.
// Master drives AW/W/AR and the B/R readys. Slave drives the rest.
interface axi_channel #(
   parameter int ID_WIDTH      = 8,
   parameter int ADDR_WIDTH    = 48,
   parameter int DATA_WIDTH    = 64,
   parameter int AW_USER_WIDTH = 1,
   parameter int AR_USER_WIDTH = 1,
   parameter int W_USER_WIDTH  = 1,
   parameter int R_USER_WIDTH  = 1,
   parameter int B_USER_WIDTH  = 1
) (
   input logic clk,
   input logic rstn
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                     aw_valid;
   logic                     aw_ready;
   logic [ID_WIDTH-1:0]      aw_id;
   logic [ADDR_WIDTH-1:0]    aw_addr;
   logic [7:0]               aw_len;
   logic [2:0]               aw_size;
   logic [1:0]               aw_burst;
   logic                     aw_lock;
   logic [3:0]               aw_cache;
   logic [2:0]               aw_prot;
   logic [3:0]               aw_qos;
   logic [3:0]               aw_region;
   logic [AW_USER_WIDTH-1:0] aw_user;

   logic                     w_valid;
   logic                     w_ready;
   logic [DATA_WIDTH-1:0]    w_data;
   logic [STRB_WIDTH-1:0]    w_strb;
   logic                     w_last;
   logic [W_USER_WIDTH-1:0]  w_user;

   logic                     b_valid;
   logic                     b_ready;
   logic [ID_WIDTH-1:0]      b_id;
   logic [1:0]               b_resp;
   logic [B_USER_WIDTH-1:0]  b_user;

   logic                     ar_valid;
   logic                     ar_ready;
   logic [ID_WIDTH-1:0]      ar_id;
   logic [ADDR_WIDTH-1:0]    ar_addr;
   logic [7:0]               ar_len;
   logic [2:0]               ar_size;
   logic [1:0]               ar_burst;
   logic                     ar_lock;
   logic [3:0]               ar_cache;
   logic [2:0]               ar_prot;
   logic [3:0]               ar_qos;
   logic [3:0]               ar_region;
   logic [AR_USER_WIDTH-1:0] ar_user;

   logic                     r_valid;
   logic                     r_ready;
   logic [ID_WIDTH-1:0]      r_id;
   logic [DATA_WIDTH-1:0]    r_data;
   logic [1:0]               r_resp;
   logic                     r_last;
   logic [R_USER_WIDTH-1:0]  r_user;

   // clk/rstn are carried for neighbours that want them; the slice runs on its own clock pins
   logic w_unused_clk_rstn;
   assign w_unused_clk_rstn = clk & rstn;

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
             aw_cache, aw_prot, aw_qos, aw_region, aw_user,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last, w_user,
      input  w_ready,
      input  b_valid, b_id, b_resp, b_user,
      output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
             ar_cache, ar_prot, ar_qos, ar_region, ar_user,
      input  ar_ready,
      input  r_valid, r_id, r_data, r_resp, r_last, r_user,
      output r_ready
   );

   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
             aw_cache, aw_prot, aw_qos, aw_region, aw_user,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last, w_user,
      output w_ready,
      output b_valid, b_id, b_resp, b_user,
      input  b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
             ar_cache, ar_prot, ar_qos, ar_region, ar_user,
      output ar_ready,
      output r_valid, r_id, r_data, r_resp, r_last, r_user,
      input  r_ready
   );
endinterface

// File: rtl/axi_modport_slice.sv
// Full AXI4 register slice: every channel passes through a two-entry skid
// buffer so valid, ready and payload are all registered at full throughput.

module axi_modport_slice_skid #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data
);
   // state | meaning
   // EMPTY | no beat held, output idle
   // ONE   | main register holds the head beat, skid register empty
   // FULL  | main and skid both hold beats, upstream stalled
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_load_main_in;
   logic             w_load_main_skid;
   logic             w_load_skid;

   assign w_in_fire  = i_in_valid & r_in_ready;
   assign w_out_fire = (r_state != EMPTY) & i_out_ready;

   // Ready resets low and rises on the first edge after reset is released
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != FULL);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_in_fire) w_state_nxt = ONE;
         ONE: begin
            if (w_out_fire && !w_in_fire)      w_state_nxt = EMPTY;
            else if (!w_out_fire && w_in_fire) w_state_nxt = FULL;
         end
         FULL:  if (w_out_fire) w_state_nxt = ONE;
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      o_out_valid      = (r_state != EMPTY);
      o_out_data       = r_main;
      o_in_ready       = r_in_ready;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         EMPTY: w_load_main_in = w_in_fire;
         ONE: begin
            w_load_main_in = w_out_fire & w_in_fire;
            w_load_skid    = !w_out_fire & w_in_fire;
         end
         FULL:  w_load_main_skid = w_out_fire;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in)        r_main <= i_in_data;
         else if (w_load_main_skid) r_main <= r_skid;
         if (w_load_skid)           r_skid <= i_in_data;
      end
   end
endmodule

module axi_modport_slice #(
   parameter int ID_WIDTH      = 8,
   parameter int ADDR_WIDTH    = 48,
   parameter int DATA_WIDTH    = 64,
   parameter int AW_USER_WIDTH = 1,
   parameter int AR_USER_WIDTH = 1,
   parameter int W_USER_WIDTH  = 1,
   parameter int R_USER_WIDTH  = 1,
   parameter int B_USER_WIDTH  = 1
) (
   input logic        clk,
   input logic        rst,
   axi_channel.slave  s,
   axi_channel.master m
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   // id + addr + len(8) size(3) burst(2) lock(1) cache(4) prot(3) qos(4) region(4) + user
   localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 29 + AW_USER_WIDTH;
   localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 29 + AR_USER_WIDTH;
   localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1 + W_USER_WIDTH;
   localparam int B_W  = ID_WIDTH + 2 + B_USER_WIDTH;
   localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + R_USER_WIDTH;

   if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
      $fatal(1, "axi_modport_slice: DATA_WIDTH must be a power of 2 in [8,1024]");
   end

   logic [AW_W-1:0] w_aw_in;
   logic [AW_W-1:0] w_aw_out;
   logic [W_W-1:0]  w_w_in;
   logic [W_W-1:0]  w_w_out;
   logic [B_W-1:0]  w_b_in;
   logic [B_W-1:0]  w_b_out;
   logic [AR_W-1:0] w_ar_in;
   logic [AR_W-1:0] w_ar_out;
   logic [R_W-1:0]  w_r_in;
   logic [R_W-1:0]  w_r_out;

   assign w_aw_in = {s.aw_id, s.aw_addr, s.aw_len, s.aw_size, s.aw_burst, s.aw_lock,
                     s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region, s.aw_user};
   assign {m.aw_id, m.aw_addr, m.aw_len, m.aw_size, m.aw_burst, m.aw_lock,
           m.aw_cache, m.aw_prot, m.aw_qos, m.aw_region, m.aw_user} = w_aw_out;

   assign w_w_in = {s.w_data, s.w_strb, s.w_last, s.w_user};
   assign {m.w_data, m.w_strb, m.w_last, m.w_user} = w_w_out;

   assign w_ar_in = {s.ar_id, s.ar_addr, s.ar_len, s.ar_size, s.ar_burst, s.ar_lock,
                     s.ar_cache, s.ar_prot, s.ar_qos, s.ar_region, s.ar_user};
   assign {m.ar_id, m.ar_addr, m.ar_len, m.ar_size, m.ar_burst, m.ar_lock,
           m.ar_cache, m.ar_prot, m.ar_qos, m.ar_region, m.ar_user} = w_ar_out;

   // Response channels run downstream to upstream
   assign w_b_in = {m.b_id, m.b_resp, m.b_user};
   assign {s.b_id, s.b_resp, s.b_user} = w_b_out;

   assign w_r_in = {m.r_id, m.r_data, m.r_resp, m.r_last, m.r_user};
   assign {s.r_id, s.r_data, s.r_resp, s.r_last, s.r_user} = w_r_out;

   axi_modport_slice_skid #(.WIDTH(AW_W)) u_aw (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (s.aw_valid),
      .o_in_ready  (s.aw_ready),
      .i_in_data   (w_aw_in),
      .o_out_valid (m.aw_valid),
      .i_out_ready (m.aw_ready),
      .o_out_data  (w_aw_out)
   );

   axi_modport_slice_skid #(.WIDTH(W_W)) u_w (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (s.w_valid),
      .o_in_ready  (s.w_ready),
      .i_in_data   (w_w_in),
      .o_out_valid (m.w_valid),
      .i_out_ready (m.w_ready),
      .o_out_data  (w_w_out)
   );

   axi_modport_slice_skid #(.WIDTH(AR_W)) u_ar (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (s.ar_valid),
      .o_in_ready  (s.ar_ready),
      .i_in_data   (w_ar_in),
      .o_out_valid (m.ar_valid),
      .i_out_ready (m.ar_ready),
      .o_out_data  (w_ar_out)
   );

   axi_modport_slice_skid #(.WIDTH(B_W)) u_b (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (m.b_valid),
      .o_in_ready  (m.b_ready),
      .i_in_data   (w_b_in),
      .o_out_valid (s.b_valid),
      .i_out_ready (s.b_ready),
      .o_out_data  (w_b_out)
   );

   axi_modport_slice_skid #(.WIDTH(R_W)) u_r (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (m.r_valid),
      .o_in_ready  (m.r_ready),
      .i_in_data   (w_r_in),
      .o_out_valid (s.r_valid),
      .i_out_ready (s.r_ready),
      .o_out_data  (w_r_out)
   );
endmodule

// File: tb/tb_axi_modport_slice.sv
// Self-checking bench for axi_modport_slice: B-channel vector table plus
// directed reset, streaming, backpressure and random R sequences.
module tb_axi_modport_slice;
   localparam int DW   = 128;
   localparam int RUW  = 4;
   localparam int R_PW = 8 + DW + 2 + 1 + RUW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi_channel #(.DATA_WIDTH(DW), .R_USER_WIDTH(RUW)) s_if (.clk(clk), .rstn(~rst));
   axi_channel #(.DATA_WIDTH(DW), .R_USER_WIDTH(RUW)) m_if (.clk(clk), .rstn(~rst));

   axi_modport_slice #(.DATA_WIDTH(DW), .R_USER_WIDTH(RUW)) dut (
      .clk (clk),
      .rst (rst),
      .s   (s_if),
      .m   (m_if)
   );

   typedef struct {
      logic       in_v;
      logic [7:0] in_id;
      logic       out_rdy;
      logic       exp_v;
      logic [7:0] exp_id;
      logic       exp_rdy;
   } b_vec_t;

   b_vec_t b_vecs [11];
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic init_inputs();
      {s_if.aw_valid, s_if.aw_id, s_if.aw_addr, s_if.aw_len, s_if.aw_size, s_if.aw_burst,
       s_if.aw_lock, s_if.aw_cache, s_if.aw_prot, s_if.aw_qos, s_if.aw_region, s_if.aw_user} = '0;
      {s_if.w_valid, s_if.w_data, s_if.w_strb, s_if.w_last, s_if.w_user} = '0;
      {s_if.ar_valid, s_if.ar_id, s_if.ar_addr, s_if.ar_len, s_if.ar_size, s_if.ar_burst,
       s_if.ar_lock, s_if.ar_cache, s_if.ar_prot, s_if.ar_qos, s_if.ar_region, s_if.ar_user} = '0;
      s_if.b_ready = 1'b0;
      s_if.r_ready = 1'b0;
      m_if.aw_ready = 1'b0;
      m_if.w_ready  = 1'b0;
      m_if.ar_ready = 1'b0;
      {m_if.b_valid, m_if.b_id, m_if.b_resp, m_if.b_user} = '0;
      {m_if.r_valid, m_if.r_id, m_if.r_data, m_if.r_resp, m_if.r_last, m_if.r_user} = '0;
   endtask

   function automatic logic [4:0] all_valids();
      return {m_if.aw_valid, m_if.w_valid, m_if.ar_valid, s_if.b_valid, s_if.r_valid};
   endfunction

   function automatic logic [4:0] all_readys();
      return {s_if.aw_ready, s_if.w_ready, s_if.ar_ready, m_if.b_ready, m_if.r_ready};
   endfunction

   initial begin
      logic [R_PW-1:0] r_q [$];
      logic [R_PW-1:0] r_exp;
      logic [R_PW-1:0] r_act;
      logic [7:0]      p_id;
      logic [DW-1:0]   p_data;
      logic [1:0]      p_resp;
      logic            p_last;
      logic [RUW-1:0]  p_user;
      logic            p_valid;
      int              sent;
      int              rcvd;
      int              cyc;

      //             in_v  in_id  ordy  exp_v exp_id exp_rdy
      b_vecs[0]  = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b1};
      b_vecs[1]  = '{1'b1, 8'd4, 1'b0, 1'b1, 8'd3, 1'b1};
      b_vecs[2]  = '{1'b1, 8'd5, 1'b0, 1'b1, 8'd3, 1'b0};
      b_vecs[3]  = '{1'b1, 8'd5, 1'b1, 1'b1, 8'd3, 1'b0};
      b_vecs[4]  = '{1'b1, 8'd5, 1'b0, 1'b1, 8'd4, 1'b1};
      b_vecs[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b0};
      b_vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b1};
      b_vecs[7]  = '{1'b1, 8'd6, 1'b1, 1'b0, 8'd0, 1'b1};
      b_vecs[8]  = '{1'b1, 8'd7, 1'b1, 1'b1, 8'd6, 1'b1};
      b_vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 1'b1};
      b_vecs[10] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1};

      init_inputs();
      #1 rst = 1'b1;

      // Power-on reset
      @(negedge clk);
      check("por_valids", all_valids(), 5'h00);
      check("por_readys", all_readys(), 5'h00);
      rst = 1'b0;
      #1 check("por_readys_before_edge", all_readys(), 5'h00);
      @(posedge clk);
      #1;
      check("por_readys_after_edge", all_readys(), 5'h1f);
      check("por_valids_after_edge", all_valids(), 5'h00);
      check("por_aw_addr_zero", m_if.aw_addr, 0);
      check("por_r_data_zero", s_if.r_data, 0);

      // B channel vector table, including skid-full with simultaneous fire
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check($sformatf("b_valid[%0d]", i), s_if.b_valid, b_vecs[i].exp_v);
         check($sformatf("b_in_ready[%0d]", i), m_if.b_ready, b_vecs[i].exp_rdy);
         if (b_vecs[i].exp_v)
            check($sformatf("b_payload[%0d]", i), {s_if.b_id, s_if.b_resp, s_if.b_user},
                  {b_vecs[i].exp_id, b_vecs[i].exp_id[1:0], b_vecs[i].exp_id[0]});
         m_if.b_valid = b_vecs[i].in_v;
         m_if.b_id    = b_vecs[i].in_id;
         m_if.b_resp  = b_vecs[i].in_id[1:0];
         m_if.b_user  = b_vecs[i].in_id[0];
         s_if.b_ready = b_vecs[i].out_rdy;
      end

      // AR backpressure
      @(negedge clk);
      m_if.ar_ready = 1'b0;
      check("ar_bp_ready0", s_if.ar_ready, 1'b1);
      s_if.ar_valid = 1'b1;
      s_if.ar_addr  = 48'h1000;
      @(negedge clk);
      check("ar_bp_valid1", m_if.ar_valid, 1'b1);
      check("ar_bp_addr1", m_if.ar_addr, 48'h1000);
      check("ar_bp_ready1", s_if.ar_ready, 1'b1);
      s_if.ar_addr = 48'h2000;
      @(negedge clk);
      check("ar_bp_full_ready", s_if.ar_ready, 1'b0);
      check("ar_bp_full_addr", m_if.ar_addr, 48'h1000);
      s_if.ar_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ar_bp_hold_valid", m_if.ar_valid, 1'b1);
         check("ar_bp_hold_addr", m_if.ar_addr, 48'h1000);
         check("ar_bp_hold_ready", s_if.ar_ready, 1'b0);
      end
      m_if.ar_ready = 1'b1;
      @(negedge clk);
      check("ar_rel_valid", m_if.ar_valid, 1'b1);
      check("ar_rel_addr2", m_if.ar_addr, 48'h2000);
      check("ar_rel_ready", s_if.ar_ready, 1'b1);
      @(negedge clk);
      check("ar_drained", m_if.ar_valid, 1'b0);

      // Random valid/ready on R with an in-order scoreboard
      sent = 0; rcvd = 0; cyc = 0; p_valid = 1'b0;
      p_id = '0; p_data = '0; p_resp = '0; p_last = 1'b0; p_user = '0;
      while (rcvd < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (!p_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
            p_valid = 1'b1;
            p_id    = 8'(sent) ^ 8'h5a;
            p_data  = {$urandom(), $urandom(), $urandom(), 32'(sent)};
            p_resp  = 2'($urandom());
            p_last  = (sent % 8) == 7;
            p_user  = RUW'($urandom());
         end
         m_if.r_valid = p_valid;
         m_if.r_id    = p_id;
         m_if.r_data  = p_data;
         m_if.r_resp  = p_resp;
         m_if.r_last  = p_last;
         m_if.r_user  = p_user;
         s_if.r_ready = ($urandom_range(0, 3) != 0);
         #4;
         if (s_if.r_valid && s_if.r_ready) begin
            r_act = {s_if.r_id, s_if.r_data, s_if.r_resp, s_if.r_last, s_if.r_user};
            if (r_q.size() != 0) r_exp = r_q.pop_front();
            else r_exp = ~r_act;
            check($sformatf("r_beat[%0d]", rcvd), r_act, r_exp);
            rcvd++;
         end
         if (m_if.r_valid && m_if.r_ready) begin
            r_q.push_back({p_id, p_data, p_resp, p_last, p_user});
            sent++;
            p_valid = 1'b0;
         end
      end
      @(negedge clk);
      m_if.r_valid = 1'b0;
      s_if.r_ready = 1'b0;
      check("r_beat_count", rcvd, 1000);
      check("r_queue_empty", r_q.size(), 0);

      // W and AR streaming at full rate while AW is stalled downstream
      m_if.w_ready  = 1'b1;
      m_if.ar_ready = 1'b1;
      m_if.aw_ready = 1'b0;
      s_if.w_strb   = '1;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         check("w_in_ready", s_if.w_ready, 1'b1);
         check("ar_in_ready", s_if.ar_ready, 1'b1);
         check("w_out_valid", m_if.w_valid, (k >= 1 && k <= 16));
         check("ar_out_valid", m_if.ar_valid, (k >= 1 && k <= 16));
         if (k >= 1 && k <= 16) begin
            check($sformatf("w_data[%0d]", k - 1), m_if.w_data, DW'(k - 1));
            check($sformatf("w_last[%0d]", k - 1), m_if.w_last, (k - 1) == 15);
            check($sformatf("ar_addr[%0d]", k - 1), m_if.ar_addr, 48'((k - 1) * 256));
         end
         if (k >= 1) begin
            check("aw_stalled_valid", m_if.aw_valid, 1'b1);
            check("aw_stalled_addr", m_if.aw_addr, 48'hA000);
         end
         if (k >= 3) check("aw_full_ready", s_if.aw_ready, 1'b0);
         s_if.aw_valid = (k < 2);
         s_if.aw_addr  = (k == 0) ? 48'hA000 : 48'hB000;
         s_if.w_valid  = (k < 16);
         s_if.w_data   = DW'(k);
         s_if.w_last   = (k == 15);
         s_if.ar_valid = (k < 16);
         s_if.ar_addr  = 48'(k * 256);
      end

      // Reset mid-stream with two AW beats buffered
      @(negedge clk);
      check("rst_pre_aw_valid", m_if.aw_valid, 1'b1);
      check("rst_pre_aw_ready", s_if.aw_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("rst_async_valids", all_valids(), 5'h00);
      check("rst_async_readys", all_readys(), 5'h00);
      check("rst_async_aw_addr", m_if.aw_addr, 0);
      @(negedge clk);
      check("rst_held_readys", all_readys(), 5'h00);
      rst = 1'b0;
      #1 check("rst_release_readys", all_readys(), 5'h00);
      @(posedge clk);
      #1;
      check("rst_after_edge_readys", all_readys(), 5'h1f);
      check("rst_after_edge_valids", all_valids(), 5'h00);
      @(negedge clk);
      m_if.aw_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_ghost_aw", m_if.aw_valid, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
